// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port OpenRAM macro between NUM_REQ requesters.
// Clears the whole array after reset or on clear_start before serving; reads return after 2 cycles.
module sram_port_arbiter #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 4,
  parameter int unsigned           NUM_REQ     = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                            clk0,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  input  logic                            clear_start,
  output logic                            init_done,
  output logic                            sram_csb0,
  output logic                            sram_web0,
  output logic [ADDR_WIDTH-1:0]           sram_addr0,
  output logic [DATA_WIDTH-1:0]           sram_din0,
  input  logic [DATA_WIDTH-1:0]           sram_dout0
);

  localparam int unsigned IDW = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned SW  = IDW + 1;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  clr_cnt;
  logic [IDW-1:0]         rr_ptr, ptr_nxt, grant_id, cand;
  logic [IDW:0]           cand_sum, nxt_sum;
  logic [NUM_REQ-1:0]     grant;
  logic                   grant_any;
  logic                   we_sel;
  logic [ADDR_WIDTH-1:0]  addr_sel;
  logic [DATA_WIDTH-1:0]  din_sel;
  logic                   hold_web;
  logic [ADDR_WIDTH-1:0]  hold_addr;
  logic [DATA_WIDTH-1:0]  hold_din;
  logic                   s1_valid;
  logic [IDW-1:0]         s1_id;

  // Cyclic search upward from rr_ptr; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    we_sel    = 1'b0;
    addr_sel  = '0;
    din_sel   = '0;
    cand_sum  = '0;
    cand      = '0;
    if (rst_n && state == SERVE && !clear_start) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr} + SW'(k);
        cand     = (cand_sum >= SW'(NUM_REQ)) ? IDW'(cand_sum - SW'(NUM_REQ)) : cand_sum[IDW-1:0];
        if (!grant_any && req_valid[cand]) begin
          grant_any   = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
          we_sel      = req_we[cand];
          addr_sel    = req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
          din_sel     = req_wdata[cand*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    nxt_sum = {1'b0, grant_id} + SW'(1);
    ptr_nxt = (nxt_sum >= SW'(NUM_REQ)) ? '0 : nxt_sum[IDW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_nxt = SERVE;
      SERVE:   if (clear_start) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Idle cycles keep the last web/addr/din on the macro pins.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = hold_web;
    sram_addr0 = hold_addr;
    sram_din0  = hold_din;
    if (!rst_n) begin
      sram_web0 = 1'b1;
    end else if (state == CLEAR) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = clr_cnt;
      sram_din0  = CLEAR_VALUE;
    end else if (grant_any) begin
      sram_csb0  = 1'b0;
      sram_web0  = ~we_sel;
      sram_addr0 = addr_sel;
      sram_din0  = din_sel;
    end
  end

  assign req_ready = grant;
  assign init_done = rst_n && (state == SERVE);

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rr_ptr    <= '0;
      hold_web  <= 1'b1;
      hold_addr <= '0;
      hold_din  <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (grant_any) rr_ptr <= ptr_nxt;
      if (!sram_csb0) begin
        hold_web  <= sram_web0;
        hold_addr <= sram_addr0;
        hold_din  <= sram_din0;
      end
      // Stage 1: macro latches the read; stage 2: dout captured with the tag.
      s1_valid  <= grant_any && !we_sel;
      s1_id     <= grant_id;
      rsp_valid <= '0;
      if (s1_valid) begin
        rsp_valid[s1_id] <= 1'b1;
        rsp_rdata        <= sram_dout0;
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port RW OpenRAM macro (clk0/csb0/web0/addr0/din0/dout0 interface) between NUM_REQ requesters using round-robin arbitration.
- After reset, or on command, sweeps the whole array and writes CLEAR_VALUE to every word before serving requests.
- Sits between the DNN layer engines (weight/bias loaders, compute readers) and the per-layer SRAM macro.
- Returns read data to the originating requester with fixed 2-cycle latency.

Parameters:
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- NUM_REQ, 2, number of requesters (2..4).
- CLEAR_VALUE, 0, word written during the clear sweep.

Ports:
- clk0, input, 1, clock; same clock as the SRAM clk0.
- rst_n, input, 1, synchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester access request.
- req_ready, output, NUM_REQ, one-hot grant; a transfer occurs when valid & ready.
- req_we, input, NUM_REQ, 1 = write, 0 = read.
- req_addr, input, NUM_REQ*ADDR_WIDTH, flattened addresses; requester i uses slice i.
- req_wdata, input, NUM_REQ*DATA_WIDTH, flattened write data.
- rsp_valid, output, NUM_REQ, one-cycle read-data strobe to the originating requester.
- rsp_rdata, output, DATA_WIDTH, registered read data; shared by all requesters.
- clear_start, input, 1, pulse that starts a clear sweep.
- init_done, output, 1, high when the array is cleared and requests are served.
- sram_csb0, output, 1, SRAM active-low chip select.
- sram_web0, output, 1, SRAM active-low write enable.
- sram_addr0, output, ADDR_WIDTH, SRAM address.
- sram_din0, output, DATA_WIDTH, SRAM write data.
- sram_dout0, input, DATA_WIDTH, SRAM read data.

Behaviour:
- Reset (rst_n=0 at posedge clk0):
  - State goes to CLEAR; clear counter = 0; rr pointer = requester 0 has priority.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - sram_csb0=1 and sram_web0=1 while rst_n is low.
  - In-flight reads are discarded; no rsp_valid for them.
- FSM states: CLEAR, SERVE.
- CLEAR:
  - Each cycle: sram_csb0=0, sram_web0=0, sram_addr0=counter, sram_din0=CLEAR_VALUE; counter increments.
  - After the write to RAM_DEPTH-1 (counter wrap), go to SERVE.
  - Sweep takes exactly RAM_DEPTH cycles; req_ready=0 throughout.
  - clear_start is ignored while in CLEAR.
- SERVE:
  - init_done=1.
  - Grant is combinational: the first requester with req_valid=1, searching upward cyclically from the rr pointer.
  - req_ready = one-hot grant. At most one grant per cycle; a requester with req_valid=0 is never granted.
  - On a transfer: sram_csb0=0, sram_web0=~req_we[i], sram_addr0/sram_din0 = requester i slices, all in the same cycle. The SRAM registers them at the next posedge.
  - After a transfer, rr pointer = (i+1) mod NUM_REQ. With no transfer the pointer holds.
  - No transfer: sram_csb0=1; sram_web0, sram_addr0 and sram_din0 hold their last values.
  - clear_start=1: no grant that cycle; go to CLEAR next cycle. Reads accepted earlier still return their responses.
- Read latency:
  - A read accepted in cycle N is registered by the SRAM at the end of N, and the SRAM drives dout0 at the negedge in N+1.
  - The arbiter samples sram_dout0 into rsp_rdata at the posedge ending N+1.
  - rsp_valid[i]=1 for exactly cycle N+2.
  - The requester id travels in a 2-stage tag pipeline.
  - Back-to-back reads give one response per cycle, in order.
- Writes produce no response.
- Ordering: a write in cycle N followed by a read of the same address in cycle N+1 returns the new data, because the SRAM write completes at the negedge in N+1 before the read.
- rsp_rdata holds its value when rsp_valid=0.

Test Plan:
- Reset then idle:
  - Stimulus: release rst_n; leave requests idle.
  - Required: exactly 16 consecutive cycles with csb0=0, web0=0, addr0=0..15, din0=0, then init_done=1. A subsequent read of any address returns 0x0000.
- Single requester write/read:
  - Stimulus: req0 writes 0xA5A5 to addr 3 in cycle N, then reads addr 3 in cycle N+1.
  - Required: rsp_valid[0]=1 in cycle N+3 with rsp_rdata=0xA5A5; rsp_valid[1] stays 0.
- Round-robin contention:
  - Stimulus: req_valid=2'b11 for 4 cycles, all reads, after the pointer was reset.
  - Required: grants in order 0,1,0,1; responses in order 0,1,0,1, each 2 cycles after its grant.
- Back-to-back streaming:
  - Stimulus: req1 preloads addr k with 0x1000+k for k=0..15, then issues 16 consecutive reads.
  - Required: 16 consecutive cycles of rsp_valid[1]=1 with data 0x1000..0x100F.
- clear_start mid-stream:
  - Stimulus: req0 read accepted in cycle N; clear_start=1 in cycle N+1.
  - Required: response still delivered in cycle N+2; init_done=0 and req_ready=0 for 16 cycles; afterwards every address reads 0x0000.
- Reset mid-operation:
  - Stimulus: rst_n=0 one cycle after a read is accepted.
  - Required: no rsp_valid for that read; csb0=1 while reset is held; a new 16-cycle clear sweep follows release.
